// File: rtl/sensor_acq_timer.sv
// Per-sensor acquisition latency timer: counts cycles from trigger to each enabled
// sensor's done level and emits a single-cycle all_done when the run completes or times out.
module sensor_acq_timer #(
    parameter int unsigned NUM_SENSORS = 6,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             trigger,
    input  logic [NUM_SENSORS-1:0]           enable_mask,
    input  logic [NUM_SENSORS-1:0]           done_in,
    input  logic [CNT_WIDTH-1:0]             timeout,
    output logic [NUM_SENSORS*CNT_WIDTH-1:0] acq_time,
    output logic [NUM_SENSORS-1:0]           done_status,
    output logic                             busy,
    output logic                             all_done,
    output logic                             timeout_err,
    output logic                             overrun
);

    localparam int unsigned ACQ_W = NUM_SENSORS * CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_SENSORS-1:0] en_q, en_d;
    logic [NUM_SENSORS-1:0] pending_q, pending_d;
    logic [NUM_SENSORS-1:0] done_status_q, done_status_d;
    logic [ACQ_W-1:0]       acq_time_q, acq_time_d;
    logic                   busy_q, busy_d;
    logic                   all_done_q, all_done_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   overrun_q, overrun_d;
    logic [NUM_SENSORS-1:0] hits;

    // Next-state and next-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        en_d          = en_q;
        pending_d     = pending_q;
        done_status_d = done_status_q;
        acq_time_d    = acq_time_q;
        busy_d        = busy_q;
        all_done_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        overrun_d     = 1'b0;
        hits          = '0;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    en_d          = enable_mask;
                    pending_d     = enable_mask;
                    done_status_d = '0;
                    timeout_err_d = 1'b0;
                    cnt_d         = CNT_WIDTH'(1);
                    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                        if (enable_mask[i]) begin
                            acq_time_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
                        end
                    end
                    if (enable_mask == '0) begin
                        state_d    = S_FIN;
                        all_done_d = 1'b1;
                    end else begin
                        state_d = S_ACQ;
                        busy_d  = 1'b1;
                    end
                end
            end

            S_ACQ: begin
                overrun_d = trigger;
                hits      = pending_q & en_q & done_in;
                for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                    if (hits[i]) begin
                        acq_time_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
                    end
                end
                pending_d     = pending_q & ~hits;
                done_status_d = done_status_q | hits;
                cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

                // A done sampled in the timeout cycle takes priority for its sensor
                if (pending_d == '0) begin
                    state_d    = S_FIN;
                    all_done_d = 1'b1;
                    busy_d     = 1'b0;
                end else if ((timeout != '0) && (cnt_q == timeout)) begin
                    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                        if (pending_d[i]) begin
                            acq_time_d[i*CNT_WIDTH +: CNT_WIDTH] = CNT_MAX;
                        end
                    end
                    pending_d     = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_FIN;
                    all_done_d    = 1'b1;
                    busy_d        = 1'b0;
                end
            end

            S_FIN: begin
                overrun_d = trigger;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            en_q          <= '0;
            pending_q     <= '0;
            done_status_q <= '0;
            acq_time_q    <= '0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            pending_q     <= pending_d;
            done_status_q <= done_status_d;
            acq_time_q    <= acq_time_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign acq_time    = acq_time_q;
    assign done_status = done_status_q;
    assign busy        = busy_q;
    assign all_done    = all_done_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sensor_acq_timer.sv
// Scoreboard bench for sensor_acq_timer: a run-level model predicts latencies, status and
// completion cycle; a monitor checks busy, all_done and overrun against the queued predictions.
`timescale 1ns/1ps
module tb_sensor_acq_timer;

    localparam int unsigned NS = 6;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CMAX = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic              trigger;
    logic [NS-1:0]     enable_mask;
    logic [NS-1:0]     done_in;
    logic [CW-1:0]     timeout;
    logic [NS*CW-1:0]  acq_time;
    logic [NS-1:0]     done_status;
    logic              busy;
    logic              all_done;
    logic              timeout_err;
    logic              overrun;

    sensor_acq_timer #(.NUM_SENSORS(NS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .enable_mask(enable_mask),
        .done_in(done_in), .timeout(timeout), .acq_time(acq_time),
        .done_status(done_status), .busy(busy), .all_done(all_done),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            trig_cyc;
        int            end_len;
        logic [NS-1:0] mask;
        logic [NS*CW-1:0] acq;
        logic [NS-1:0] status;
        logic          terr;
    } exp_t;

    exp_t sb_q[$];
    int   ovr_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    logic [CW-1:0] model_acq [NS];
    int            run_d [NS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void set_d(input int a, input int b, input int c, input int d, input int e, input int f);
        run_d[0] = a; run_d[1] = b; run_d[2] = c; run_d[3] = d; run_d[4] = e; run_d[5] = f;
    endfunction

    // Run-level model: the run ends at the last enabled done, or at the timeout if that comes first
    task automatic do_run(input logic [NS-1:0] mask, input logic [CW-1:0] to, input int ovr_sel, input int gap);
        exp_t e;
        int   mx;
        int   ovr_rel;
        mx = 0;
        for (int i = 0; i < NS; i++) if (mask[i] && run_d[i] > mx) mx = run_d[i];
        e.terr = 1'b0;
        if (to != '0 && mx > int'(to)) begin
            e.end_len = int'(to);
            e.terr    = 1'b1;
        end else begin
            e.end_len = mx;
        end
        e.status = '0;
        for (int i = 0; i < NS; i++) begin
            if (mask[i]) begin
                if (run_d[i] <= e.end_len) begin
                    model_acq[i] = (run_d[i] > int'(CMAX)) ? CMAX : CW'(run_d[i]);
                    e.status[i]  = 1'b1;
                end else begin
                    model_acq[i] = CMAX;
                end
            end
        end
        for (int i = 0; i < NS; i++) e.acq[i*CW +: CW] = model_acq[i];
        e.mask = mask;
        ovr_rel = (ovr_sel < 0) ? $urandom_range(1, e.end_len + 1) : ovr_sel;

        @(posedge clk); #1;
        e.trig_cyc = cyc;
        sb_q.push_back(e);
        trigger     = 1'b1;
        enable_mask = mask;
        timeout     = to;
        done_in     = NS'($urandom) & ~mask;
        for (int rel = 1; rel <= e.end_len + 1; rel++) begin
            @(posedge clk); #1;
            trigger = (rel == ovr_rel);
            if (trigger) ovr_q.push_back(cyc + 1);
            enable_mask = NS'($urandom);
            for (int i = 0; i < NS; i++) done_in[i] = mask[i] ? (rel >= run_d[i]) : 1'($urandom);
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            trigger = 1'b0;
            done_in = '0;
        end
    endtask

    // Stimulus
    initial begin
        exp_t er;
        logic [NS-1:0] m;
        logic [CW-1:0] t;
        rst = 1'b1; trigger = 1'b0; enable_mask = '0; done_in = '0; timeout = '0;
        for (int i = 0; i < NS; i++) model_acq[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        set_d(5, 9, 0, 0, 0, 0);             do_run(6'b000011, 16'd0, 0, 1);
        set_d(0, 0, 7, 1000, 1000, 1000);    do_run(6'b111100, 16'd20, 0, 1);
        set_d(4, 0, 0, 0, 0, 0);             do_run(6'b000001, 16'd4, 0, 1);
        set_d(0, 0, 0, 0, 0, 0);             do_run(6'b000000, 16'd0, 0, 0);
        set_d(6, 0, 0, 0, 0, 0);             do_run(6'b000001, 16'd0, 3, 1);
        set_d(5, 9, 0, 0, 0, 0);             do_run(6'b000011, 16'd0, 0, 1);
        set_d(3, 0, 0, 0, 0, 0);             do_run(6'b000001, 16'd0, 0, 0);
        set_d(2, 8, 30, 1000, 1, 12);        do_run(6'b110111, 16'd25, 0, 0);

        // Abort a run at cycle 6 with reset
        @(posedge clk); #1;
        er.trig_cyc = cyc; er.end_len = 10; er.mask = '1;
        er.acq = '0; er.status = '0; er.terr = 1'b0;
        sb_q.push_back(er);
        trigger = 1'b1; enable_mask = '1; timeout = '0; done_in = '0;
        repeat (6) begin @(posedge clk); #1 trigger = 1'b0; end
        #2 rst = 1'b1;
        for (int i = 0; i < NS; i++) model_acq[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_d(3, 4, 5, 6, 7, 8);             do_run(6'b111111, 16'd0, 0, 1);

        for (int r = 0; r < 40; r++) begin
            m = NS'($urandom);
            t = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(1, 40));
            set_d($urandom_range(1, 50), $urandom_range(1, 50), $urandom_range(1, 50),
                  $urandom_range(1, 50), $urandom_range(1, 50), $urandom_range(1, 50));
            do_run(m, t, ($urandom_range(0, 2) == 0) ? -1 : 0, $urandom_range(0, 2));
        end

        set_d(65540, 0, 0, 0, 0, 0);         do_run(6'b000001, 16'd0, 0, 1);
        repeat (5) @(posedge clk);
        #1 stim_done = 1'b1;
    end

    // Monitor
    initial begin
        exp_t e;
        bit   busy_exp;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                sb_q.delete();
                ovr_q.delete();
                chk(acq_time == '0, "reset_acq_time", 128'(acq_time), 128'(0));
                chk({done_status, busy, all_done, timeout_err, overrun} == '0, "reset_flags",
                    128'({done_status, busy, all_done, timeout_err, overrun}), 128'(0));
            end else if (stim_done) begin
                chk(sb_q.size() == 0, "pending_runs", 128'(sb_q.size()), 128'(0));
                chk(ovr_q.size() == 0, "pending_overruns", 128'(ovr_q.size()), 128'(0));
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end else begin
                busy_exp = (sb_q.size() > 0) && (sb_q[0].mask != '0) &&
                           (cyc > sb_q[0].trig_cyc) && (cyc <= sb_q[0].trig_cyc + sb_q[0].end_len);
                chk(busy == busy_exp, "busy", 128'(busy), 128'(busy_exp));

                if (all_done) begin
                    chk(sb_q.size() > 0, "unexpected_all_done", 128'(all_done), 128'(0));
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk(cyc == e.trig_cyc + e.end_len + 1, "all_done_cycle",
                            128'(cyc - e.trig_cyc), 128'(e.end_len + 1));
                        chk(acq_time == e.acq, "acq_time", 128'(acq_time), 128'(e.acq));
                        chk(done_status == e.status, "done_status", 128'(done_status), 128'(e.status));
                        chk(timeout_err == e.terr, "timeout_err", 128'(timeout_err), 128'(e.terr));
                    end
                end else if (sb_q.size() > 0 && cyc > sb_q[0].trig_cyc + sb_q[0].end_len + 1) begin
                    chk(all_done, "missing_all_done", 128'(all_done), 128'(1));
                    void'(sb_q.pop_front());
                end

                if (overrun) begin
                    chk(ovr_q.size() > 0 && ovr_q[0] == cyc, "overrun_cycle", 128'(cyc),
                        128'((ovr_q.size() > 0) ? ovr_q[0] : -1));
                    if (ovr_q.size() > 0) void'(ovr_q.pop_front());
                end else if (ovr_q.size() > 0 && ovr_q[0] <= cyc) begin
                    chk(overrun, "missing_overrun", 128'(overrun), 128'(1));
                    void'(ovr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sensor_acq_timer.md
# sensor_acq_timer

Measures per-sensor acquisition latency for one sampling event and produces the aggregated completion pulse for the scheduler. Sits directly downstream of the PWM-synchronised trigger and in front of the timing manager's done logic. For each sensor enabled in a run-time mask, it counts clock cycles from `trigger` until that sensor's done signal is high. It then raises `all_done` once every enabled sensor has reported or a timeout expires.

## Interface
- `NUM_SENSORS`, 6, number of sensor done lines. Bit order: 0=adc, 1=encoder, 2..5=eddy_0..eddy_3.
- `CNT_WIDTH`, 16, width of the cycle counter and each latency field.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `trigger` input 1: start-of-acquisition pulse, sampled each cycle.
- `enable_mask` input NUM_SENSORS: sensors included in the run; sampled only on an accepted trigger.
- `done_in` input NUM_SENSORS: per-sensor done, level-sampled.
- `timeout` input CNT_WIDTH: cycle limit per run; 0 disables the timeout.
- `acq_time` output NUM_SENSORS*CNT_WIDTH: latency of sensor i in bits [i*CNT_WIDTH +: CNT_WIDTH].
- `done_status` output NUM_SENSORS: sensors that have reported in the current or last run.
- `busy` output 1: high while a run is in progress.
- `all_done` output 1: one-cycle completion pulse.
- `timeout_err` output 1: set when a run ends by timeout; held until the next accepted trigger.
- `overrun` output 1: one-cycle pulse when a trigger arrives while busy.

## Operation
- **States:**
  - IDLE.
  - ACQ.
  - FIN (single cycle in which `all_done` is asserted).
- **IDLE**
  - `trigger`=1 is an accepted trigger. It does all of the following:
    - latches `enable_mask` into `en_q`;
    - sets `pending` = `enable_mask`;
    - clears `done_status`, `timeout_err`, and every `acq_time` field of an enabled sensor (disabled fields keep their value);
    - sets counter = 1;
    - goes to ACQ.
  - If `enable_mask`=0, it goes directly to FIN instead.
- **ACQ, each cycle:**
  - For every i with `pending[i]`=1 and `done_in[i]`=1:
    - `acq_time[i]` <= counter;
    - `pending[i]` <= 0;
    - `done_status[i]` <= 1.
  - Counter increments, saturating at 2^CNT_WIDTH-1.
  - If every pending bit is cleared in this cycle, go to FIN.
  - Otherwise, if `timeout` != 0 and counter == `timeout`:
    - every still-pending field gets all-ones;
    - `pending` <= 0;
    - `timeout_err` <= 1;
    - go to FIN.
- **FIN:**
  - `all_done` = 1;
  - next state IDLE.
  - A trigger here is an overrun and is not accepted.
- **Overrun:** `trigger`=1 in ACQ or FIN pulses `overrun` the next cycle. It has no effect on the run.
- `done_in` bits of disabled sensors are ignored.
- A done that is already high at trigger time is recorded with latency 1 in the first ACQ cycle. Upstream must deassert stale done levels before triggering.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0, `pending`/`en_q` 0. Reset mid-run aborts immediately with no `all_done`.
- **Trigger to busy:** trigger accepted at edge k gives `busy`=1 from cycle k+1.
- **Latency definition:** `acq_time` = number of ACQ cycles up to and including the cycle in which done is sampled high. Done high in the first cycle after trigger gives 1.
- **Completion:** `all_done` asserts the cycle after the last pending done is sampled (or the timeout cycle) and lasts exactly one cycle. `busy` falls with it, so `busy` is low in the cycle `all_done` is high.
- **Empty mask:** `all_done` asserts the cycle after the trigger; `busy` never rises.
- **Simultaneous done and timeout:** the done wins for that sensor. If it was the last pending sensor, `timeout_err` stays 0.
- **Saturation:** if the counter saturates and `timeout`=0, the run waits indefinitely and the latency reads 0xFFFF.
- **Output stability:** `acq_time`, `done_status` and `timeout_err` are stable from `all_done` until the next accepted trigger.
- **Back-to-back runs:** a trigger in the cycle after FIN (IDLE) is accepted. Minimum trigger spacing is therefore run length + 2 cycles.

## Test plan
- **Basic run:**
  - Stimulus: mask=0b000011, timeout=0; trigger at cycle 0; adc done high at cycle 5, encoder done at cycle 9.
  - Required: `acq_time[0]`=5, `acq_time[1]`=9, `all_done` pulse at cycle 10, `busy` high for cycles 1–9.
- **Timeout:**
  - Stimulus: mask=0b111100, timeout=20; only eddy_0 done at cycle 7.
  - Required: `acq_time[2]`=7, fields 3–5 = 0xFFFF, `timeout_err`=1, `all_done` at cycle 21.
- **Tie:**
  - Stimulus: mask=0b000001, timeout=4; adc done at cycle 4.
  - Required: `acq_time[0]`=4, `timeout_err`=0, `all_done` at cycle 5.
- **Empty mask and overrun:**
  - Stimulus: mask=0, trigger.
  - Required: `all_done` the next cycle, `busy` never high.
  - Stimulus: mask=1, trigger again at cycle 3 of the run.
  - Required: `overrun` pulse at cycle 4; the run continues and its latencies are unaffected.
- **Reset mid-run:**
  - Stimulus: assert `rst` at cycle 6 of a run.
  - Required: all outputs 0 asynchronously, no `all_done`; the next trigger after reset starts a clean run with latencies correct.
- **Disabled-field retention:**
  - Stimulus: run 1 with mask=0b000011; run 2 with mask=0b000001.
  - Required: `acq_time[1]` keeps the run-1 value; `done_status` = 0b000001 after run 2.
